vote_session_counter: RTL and testbench

Parametrised, clocked successor to the combinational 3-voter counter. It runs a voting session for `N` voters and accepts at most one yes/no ballot per voter while the session is open. Any number of voters may cast in the same cycle. It keeps registered yes/no tallies, a one-hot yes count and a majority/tie verdict, and closes on command or automatically once every voter has cast. It sits between the voter input logic and the result display/decision logic.

---
 rtl/vote_pkg.sv | 20 ++
 rtl/vote_popcount.sv | 17 +
 rtl/vote_session_counter.sv | 107 ++++++++++
 tb/tb_vote_session_counter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and helpers for the voting session counter.
package vote_pkg;

  typedef enum logic [1:0] {IDLE, OPEN_S, CLOSED} vote_state_t;

  localparam int MAX_VOTERS = 32;

  // Returns a one-hot vector with bit 'value' set, limited to the low 'width' bits.
  function automatic logic [MAX_VOTERS:0] onehot_count(input logic [5:0] value, input int width);
    logic [MAX_VOTERS:0] result;
    result = '0;
    for (int k = 0; k <= MAX_VOTERS; k++) begin
      if (k < width && value == 6'(k)) begin
        result[k] = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of an N-bit ballot vector.
module vote_popcount #(
  parameter int N  = 3,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/vote_session_counter.sv
// Voting session FSM with registered yes/no tallies, one-hot yes count and verdict.
module vote_session_counter
  import vote_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    START,
  input  logic                    CLOSE,
  input  logic [N-1:0]            C,
  input  logic [N-1:0]            V,
  output logic [N:0]              R,
  output logic [$clog2(N+1)-1:0]  YES,
  output logic [$clog2(N+1)-1:0]  NO,
  output logic [N-1:0]            CAST,
  output logic                    MAJ,
  output logic                    TIE,
  output logic                    OPEN,
  output logic                    DONE
);

  localparam int CW = $clog2(N + 1);

  vote_state_t    state_q, state_d;
  logic [CW-1:0]  yes_q, yes_d, no_q, no_d;
  logic [N-1:0]   cast_q, cast_d;
  logic [N:0]     r_q, r_d;
  logic           maj_q, maj_d, tie_q, tie_d, done_q, done_d;

  logic [N-1:0]   acc;
  logic [CW-1:0]  yesCnt, noCnt;

  // Only first-time ballots in an open session are accepted.
  assign acc = (state_q == OPEN_S) ? (C & ~cast_q) : '0;

  vote_popcount #(.N(N), .CW(CW)) u_yesCount (.vec(acc & V),  .count(yesCnt));
  vote_popcount #(.N(N), .CW(CW)) u_noCount  (.vec(acc & ~V), .count(noCnt));

  always_comb begin
    state_d = state_q;
    yes_d   = yes_q;
    no_d    = no_q;
    cast_d  = cast_q;
    maj_d   = maj_q;
    tie_d   = tie_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, CLOSED: begin
        if (START) begin
          state_d = OPEN_S;
          yes_d   = '0;
          no_d    = '0;
          cast_d  = '0;
          maj_d   = 1'b0;
          tie_d   = 1'b0;
        end
      end
      OPEN_S: begin
        cast_d = cast_q | acc;
        yes_d  = yes_q + yesCnt;
        no_d   = no_q + noCnt;
        // The verdict is taken from the tallies including this cycle's ballots.
        if (CLOSE || cast_d == {N{1'b1}}) begin
          state_d = CLOSED;
          done_d  = 1'b1;
          maj_d   = yes_d > no_d;
          tie_d   = yes_d == no_d;
        end
      end
      default: state_d = IDLE;
    endcase
    r_d = (N+1)'(onehot_count(6'(yes_d), N + 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      yes_q   <= '0;
      no_q    <= '0;
      cast_q  <= '0;
      r_q     <= (N+1)'(1);
      maj_q   <= 1'b0;
      tie_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      yes_q   <= yes_d;
      no_q    <= no_d;
      cast_q  <= cast_d;
      r_q     <= r_d;
      maj_q   <= maj_d;
      tie_q   <= tie_d;
      done_q  <= done_d;
    end
  end

  assign R    = r_q;
  assign YES  = yes_q;
  assign NO   = no_q;
  assign CAST = cast_q;
  assign MAJ  = maj_q;
  assign TIE  = tie_q;
  assign OPEN = (state_q == OPEN_S);
  assign DONE = done_q;

endmodule

// File: tb/tb_vote_session_counter.sv
// Self-checking bench: directed scenarios then random traffic against a per-voter ballot model.
module tb_vote_session_counter;

  localparam int N  = 3;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst, start, close;
  logic [N-1:0]  c, v;
  logic [N:0]    rOut;
  logic [CW-1:0] yesOut, noOut;
  logic [N-1:0]  castOut;
  logic          majOut, tieOut, openOut, doneOut;

  int assertCount = 0;
  int failCount   = 0;

  typedef enum int {M_IDLE, M_OPEN, M_CLOSED} model_phase_t;
  model_phase_t phase;
  int           ballot [N];
  logic         expMaj, expTie, expDone;

  vote_session_counter #(.N(N)) dut (
    .clk(clk), .rst(rst), .START(start), .CLOSE(close), .C(c), .V(v),
    .R(rOut), .YES(yesOut), .NO(noOut), .CAST(castOut),
    .MAJ(majOut), .TIE(tieOut), .OPEN(openOut), .DONE(doneOut)
  );

  always #5 clk = ~clk;

  function automatic int countBallots(input int kind);
    int n = 0;
    for (int i = 0; i < N; i++) if (ballot[i] == kind) n++;
    return n;
  endfunction

  function automatic logic [N-1:0] castMask();
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = (ballot[i] != 0);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ballot codes: 0 = not cast, 1 = yes, 2 = no.
  task automatic modelUpdate();
    if (rst) begin
      phase = M_IDLE;
      for (int i = 0; i < N; i++) ballot[i] = 0;
      expMaj = 0; expTie = 0; expDone = 0;
    end else begin
      expDone = 0;
      case (phase)
        M_IDLE, M_CLOSED: if (start) begin
          phase = M_OPEN;
          for (int i = 0; i < N; i++) ballot[i] = 0;
          expMaj = 0; expTie = 0;
        end
        M_OPEN: begin
          for (int i = 0; i < N; i++)
            if (c[i] && ballot[i] == 0) ballot[i] = v[i] ? 1 : 2;
          if (close || countBallots(0) == 0) begin
            phase   = M_CLOSED;
            expDone = 1;
            expMaj  = countBallots(1) > countBallots(2);
            expTie  = countBallots(1) == countBallots(2);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput(input string tag);
    int y = countBallots(1);
    int n = countBallots(2);
    check({tag, ".YES"},  32'(yesOut),  32'(y));
    check({tag, ".NO"},   32'(noOut),   32'(n));
    check({tag, ".R"},    32'(rOut),    32'(1) << y);
    check({tag, ".CAST"}, 32'(castOut), 32'(castMask()));
    check({tag, ".MAJ"},  32'(majOut),  32'(expMaj));
    check({tag, ".TIE"},  32'(tieOut),  32'(expTie));
    check({tag, ".OPEN"}, 32'(openOut), 32'(phase == M_OPEN));
    check({tag, ".DONE"}, 32'(doneOut), 32'(expDone));
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic s, input logic cl,
                               input logic [N-1:0] cv, input logic [N-1:0] vv);
    @(negedge clk);
    rst = r; start = s; close = cl; c = cv; v = vv;
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1; start = 0; close = 0; c = '0; v = '0;
    phase = M_IDLE; expMaj = 0; expTie = 0; expDone = 0;
    for (int i = 0; i < N; i++) ballot[i] = 0;

    applyStimulus("reset0", 1, 0, 0, 3'b000, 3'b000);
    applyStimulus("reset1", 1, 1, 1, 3'b111, 3'b111);
    check("resetR", 32'(rOut), 32'h1);
    for (int k = 0; k < 3; k++) applyStimulus("idle", 0, 0, 0, 3'b000, 3'b000);
    applyStimulus("idleCast", 0, 0, 1, 3'b111, 3'b111);

    // Split cast then auto-close on the last voter.
    applyStimulus("open1", 0, 1, 0, 3'b000, 3'b000);
    applyStimulus("cast101", 0, 0, 0, 3'b101, 3'b100);
    check("cast101.literal", 32'({yesOut, noOut, castOut}), 32'({2'd1, 2'd1, 3'b101}));
    applyStimulus("autoClose", 0, 0, 0, 3'b010, 3'b010);
    check("autoClose.literal", 32'({rOut, majOut, doneOut}), 32'({4'b0100, 1'b1, 1'b1}));
    applyStimulus("doneDrop", 0, 0, 0, 3'b000, 3'b000);

    // Restart drops same-cycle ballots; repeat cast ignored.
    applyStimulus("restart", 0, 1, 0, 3'b111, 3'b111);
    applyStimulus("v0yes", 0, 0, 0, 3'b001, 3'b001);
    applyStimulus("v0no", 0, 0, 0, 3'b001, 3'b000);
    applyStimulus("closeRepeat", 0, 0, 1, 3'b000, 3'b000);
    check("closeRepeat.literal", 32'({yesOut, noOut, castOut, majOut, tieOut}),
          32'({2'd1, 2'd0, 3'b001, 1'b1, 1'b0}));

    // Ballots with CLOSE in the same cycle are counted.
    applyStimulus("open3", 0, 1, 0, 3'b000, 3'b000);
    applyStimulus("castClose", 0, 0, 1, 3'b011, 3'b001);
    check("castClose.literal", 32'({tieOut, majOut, rOut}), 32'({1'b1, 1'b0, 4'b0010}));

    // START with CLOSE in OPEN: CLOSE wins. Empty session gives a tie.
    applyStimulus("open4", 0, 1, 0, 3'b000, 3'b000);
    applyStimulus("startClose", 0, 1, 1, 3'b000, 3'b000);
    applyStimulus("closedClose", 0, 0, 1, 3'b111, 3'b000);

    // Reset mid-session with casts active.
    applyStimulus("open5", 0, 1, 0, 3'b000, 3'b000);
    applyStimulus("cast010", 0, 0, 0, 3'b010, 3'b010);
    applyStimulus("midReset", 1, 0, 0, 3'b111, 3'b111);

    for (int k = 0; k < 400; k++) begin
      applyStimulus("random", ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 9) == 0), N'($urandom), N'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
